trivium_stream_cipher: RTL

Parametrised Trivium stream-cipher datapath that sits between the UART receive path and the TX FIFO. It loads an 80-bit key and IV and runs the 1152-round warm-up. It then XORs each WORD_W-bit input beat with the next WORD_W keystream bits. Both sides use valid/ready handshakes; a per-beat bypass mode passes data through unchanged without consuming keystream.

---
 rtl/trivium_stream_cipher.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/trivium_stream_cipher.sv
// Trivium keystream generator with valid/ready XOR datapath and per-beat bypass.
// UNROLL rounds per clock; keystream is packed LSB-first into a WORD_W buffer.
//
// state | meaning
// IDLE  | no key loaded; only bypass beats pass
// INIT  | 1152-round warm-up in progress, busy = 1
// RUN   | keystream generation, ks_ready = 1
module trivium_stream_cipher #(
  parameter int WORD_W = 8,
  parameter int UNROLL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [79:0]       key,
  input  logic [79:0]       iv,
  input  logic              load,
  output logic              busy,
  output logic              ks_ready,
  input  logic              bypass,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int INIT_CYC = 1152 / UNROLL;
  localparam int CNT_W    = $clog2(INIT_CYC + 1);
  localparam int SLICES   = WORD_W / UNROLL;
  localparam int FILL_W   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(INIT_CYC - 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SLICES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [287:0]        s_q, s_adv, st_work, load_state;
  logic [288:0]        rnd;
  logic [UNROLL-1:0]   z_slice;
  logic [CNT_W-1:0]    cnt_q;
  logic [WORD_W-1:0]   ks_word_q;
  logic [FILL_W-1:0]   ks_fill_q;
  logic                ks_valid_q;
  logic                in_fire, ks_take, gen_en, adv;

  // Returns {z, next_state}; bit i of the state vector holds s(i+1).
  function automatic logic [288:0] trivium_round(input logic [287:0] s);
    logic t1, t2, t3, z;
    t1 = s[65] ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90] & s[91]) ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endfunction

  assign load_state = {3'b111, 108'd0, 4'd0, iv, 13'd0, key};

  always_comb begin
    st_work = s_q;
    rnd     = '0;
    z_slice = '0;
    for (int i = 0; i < UNROLL; i++) begin
      rnd        = trivium_round(st_work);
      z_slice[i] = rnd[288];
      st_work    = rnd[287:0];
    end
    s_adv = st_work;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    ks_ready = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_INIT: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = ST_RUN;
      end
      ST_RUN:  ks_ready = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    if (load) state_d = ST_INIT;
  end

  // Bypass beats are held back only by load and output back-pressure.
  assign in_ready = (!out_valid || out_ready) && !load &&
                    (bypass || (ks_valid_q && !busy));
  assign in_fire  = in_valid && in_ready;
  assign ks_take  = in_fire && !bypass;
  assign gen_en   = (state_q == ST_RUN) && (!ks_valid_q || ks_take);
  assign adv      = (state_q == ST_INIT) || gen_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= INIT_LAST;
    end else if (state_q == ST_INIT && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    s_q <= '0;
    else if (load) s_q <= load_state;
    else if (adv)  s_q <= s_adv;
  end

  // The fill index is always zero while the word is valid, so a consuming
  // cycle starts writing the next word at slice 0 without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_word_q  <= '0;
      ks_fill_q  <= '0;
      ks_valid_q <= 1'b0;
    end else if (load) begin
      ks_fill_q  <= '0;
      ks_valid_q <= 1'b0;
    end else begin
      if (ks_take) ks_valid_q <= 1'b0;
      if (gen_en) begin
        ks_word_q[int'(ks_fill_q) * UNROLL +: UNROLL] <= z_slice;
        if (ks_fill_q == FILL_LAST) begin
          ks_fill_q  <= '0;
          ks_valid_q <= 1'b1;
        end else begin
          ks_fill_q <= ks_fill_q + FILL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= bypass ? in_data : (in_data ^ ks_word_q);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
